// File: rtl/updn_pkg.sv
// rtl/updn_pkg.sv - shared types and helpers for the up/down vote filter
package updn_pkg;

    typedef enum logic [1:0] {
        ST_ACQ    = 2'd0,
        ST_DECIDE = 2'd1,
        ST_HOLD   = 2'd2
    } updn_state_t;

    localparam logic UP = 1'b1;
    localparam logic DN = 1'b0;

    // Signed accumulator width able to hold +/-win
    function automatic int acc_w(input int win);
        return $clog2(win + 1) + 1;
    endfunction

endpackage

// File: rtl/updn_lock_det.sv
// rtl/updn_lock_det.sv - counts consecutive no-step windows and flags lock
module updn_lock_det
    import updn_pkg::*;
#(
    parameter int LOCK_CNT = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic win_done,
    input  logic step,
    output logic locked
);

    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

    logic [CNT_W-1:0] r_quiet_cnt;

    // Count quiet windows, saturating; a step restarts the count
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_quiet_cnt <= '0;
        end else if (step) begin
            r_quiet_cnt <= '0;
        end else if (win_done && (r_quiet_cnt != CNT_MAX)) begin
            r_quiet_cnt <= r_quiet_cnt + 1'b1;
        end
    end

    assign locked = (r_quiet_cnt == CNT_MAX);

endmodule

// File: rtl/updn_vote_filter.sv
// rtl/updn_vote_filter.sv - windowed phase-vote filter driving the up/down step counter (LOCK_DET_EN adds lock detect)
module updn_vote_filter
    import updn_pkg::*;
#(
    parameter  int WIN      = 8,
    parameter  int THRESH   = 4,
    parameter  int HOLD_CYC = 2,
    parameter  int LOCK_CNT = 4,
    localparam int ACC_W    = acc_w(WIN)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             pd_valid,
    input  logic             pd_up,
    output logic             up_dnb,
    output logic             step,
    output logic             win_done,
    output logic [ACC_W-1:0] acc_dbg,
    output logic             locked
);

    localparam int VCNT_W = $clog2(WIN + 1);
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [VCNT_W-1:0]       VCNT_LAST = VCNT_W'(WIN - 1);
    localparam logic [HOLD_W-1:0]       HOLD_INIT = (HOLD_CYC > 0) ? HOLD_W'(HOLD_CYC - 1) : '0;
    localparam logic signed [ACC_W-1:0] ONE       = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] THR_POS   = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_NEG   = -THR_POS;

    if (WIN < 2) begin : g_bad_win
        $error("WIN must be at least 2");
    end
    if ((THRESH < 1) || (THRESH > WIN)) begin : g_bad_thresh
        $error("THRESH must be within 1..WIN");
    end
    if (HOLD_CYC < 0) begin : g_bad_hold
        $error("HOLD_CYC must be non-negative");
    end
    if (LOCK_CNT < 1) begin : g_bad_lock
        $error("LOCK_CNT must be at least 1");
    end

    updn_state_t              r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [VCNT_W-1:0]        r_vcnt;
    logic [HOLD_W-1:0]        r_hold_cnt;
    logic                     r_up_dnb;
    logic                     r_step;
    logic                     r_win_done;

    logic                     w_decide;
    logic                     w_step_up;
    logic                     w_step_dn;
    logic                     w_step;
    logic signed [ACC_W-1:0]  w_vote;

    assign w_decide  = (r_state == ST_DECIDE);
    assign w_step_up = w_decide && (r_acc >= THR_POS);
    assign w_step_dn = w_decide && (r_acc <= THR_NEG);
    assign w_step    = w_step_up || w_step_dn;
    assign w_vote    = pd_up ? ONE : -ONE;

    // Window FSM: accumulate votes, decide once per window, then blank after a step
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= ST_ACQ;
            r_acc      <= '0;
            r_vcnt     <= '0;
            r_hold_cnt <= '0;
            r_up_dnb   <= UP;
        end else begin
            case (r_state)
                ST_ACQ: begin
                    if (pd_valid) begin
                        r_acc  <= r_acc + w_vote;
                        r_vcnt <= r_vcnt + 1'b1;
                        if (r_vcnt == VCNT_LAST) begin
                            r_state <= ST_DECIDE;
                        end
                    end
                end
                ST_DECIDE: begin
                    r_acc  <= '0;
                    r_vcnt <= '0;
                    if (w_step_up) begin
                        r_up_dnb <= UP;
                    end else if (w_step_dn) begin
                        r_up_dnb <= DN;
                    end
                    if (w_step && (HOLD_CYC > 0)) begin
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= HOLD_INIT;
                    end else begin
                        r_state <= ST_ACQ;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state <= ST_ACQ;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_ACQ;
                end
            endcase
        end
    end

    // One-cycle strobes, registered from the decide cycle
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_step     <= 1'b0;
            r_win_done <= 1'b0;
        end else begin
            r_step     <= w_step;
            r_win_done <= w_decide;
        end
    end

    assign up_dnb   = r_up_dnb;
    assign step     = r_step;
    assign win_done = r_win_done;
    assign acc_dbg  = r_acc;

`ifdef LOCK_DET_EN
    // Fed from the decide-cycle terms so locked moves on the same edge as step
    updn_lock_det #(
        .LOCK_CNT (LOCK_CNT)
    ) u_lock_det (
        .clk      (clk),
        .rstb     (rstb),
        .win_done (w_decide),
        .step     (w_step),
        .locked   (locked)
    );
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_updn_vote_filter.sv
// tb/tb_updn_vote_filter.sv - scoreboard bench for updn_vote_filter
module tb_updn_vote_filter;

    localparam int WIN      = 8;
    localparam int THRESH   = 4;
    localparam int HOLD_CYC = 2;
    localparam int LOCK_CNT = 4;
    localparam int ACC_W    = $clog2(WIN + 1) + 1;
`ifdef LOCK_DET_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstb = 1'b0;
    logic             pd_valid = 1'b0;
    logic             pd_up = 1'b0;
    logic             up_dnb;
    logic             step;
    logic             win_done;
    logic [ACC_W-1:0] acc_dbg;
    logic             locked;

    updn_vote_filter #(
        .WIN      (WIN),
        .THRESH   (THRESH),
        .HOLD_CYC (HOLD_CYC),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .pd_valid (pd_valid),
        .pd_up    (pd_up),
        .up_dnb   (up_dnb),
        .step     (step),
        .win_done (win_done),
        .acc_dbg  (acc_dbg),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int sum;
        bit step;
        bit dir;
        bit locked;
        int at_cyc;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: votes in a window are just counted; after a full window
    // the filter is deaf for one decide cycle plus HOLD_CYC cycles if it stepped.
    int m_nacc = 0;
    int m_sum  = 0;
    int m_deaf = 0;
    int m_quiet = 0;
    bit m_dir  = 1'b1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        m_nacc = 0;
        m_sum  = 0;
        m_deaf = 0;
        m_quiet = 0;
        m_dir  = 1'b1;
        exp_q.delete();
    endtask

    task automatic model_vote(input bit v, input bit u);
        exp_t e;
        if (m_deaf > 0) begin
            m_deaf--;
        end else if (v) begin
            m_nacc++;
            m_sum += u ? 1 : -1;
            if (m_nacc == WIN) begin
                e.sum  = m_sum;
                e.step = (m_sum >= THRESH) || (m_sum <= -THRESH);
                if (e.step) m_dir = (m_sum > 0);
                e.dir = m_dir;
                if (e.step) m_quiet = 0;
                else if (m_quiet < LOCK_CNT) m_quiet++;
                e.locked = LOCK_EN && (m_quiet == LOCK_CNT);
                e.at_cyc = cyc + 2;
                exp_q.push_back(e);
                m_deaf = 1 + (e.step ? HOLD_CYC : 0);
                m_nacc = 0;
                m_sum  = 0;
            end
        end
    endtask

    // Drive one cycle of input, shortly after the falling edge
    task automatic vote(input bit v, input bit u);
        @(negedge clk);
        #1;
        pd_valid = v;
        pd_up    = u;
        model_vote(v, u);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) vote(1'b0, 1'b0);
    endtask

    task automatic window(input int n_up, input int n_dn);
        for (int i = 0; i < n_up; i++) vote(1'b1, 1'b1);
        for (int i = 0; i < n_dn; i++) vote(1'b1, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_up_dnb"}, up_dnb, 1);
        check({tag, "_step"}, step, 0);
        check({tag, "_win_done"}, win_done, 0);
        check({tag, "_acc_dbg"}, int'($signed(acc_dbg)), 0);
        check({tag, "_locked"}, locked, 0);
    endtask

    // Monitor: pop the expected decision whenever the DUT reports a window end
    exp_t mon_e;
    int   prev_acc = 0;
    bit   prev_wd  = 1'b0;
    always @(negedge clk) begin
        if (rstb) begin
            if (win_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_win_done", 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("win_done_cycle", cyc, mon_e.at_cyc);
                    check("acc_before_decide", prev_acc, mon_e.sum);
                    check("step", step, mon_e.step);
                    check("up_dnb", up_dnb, mon_e.dir);
                    check("locked", locked, mon_e.locked);
                    check("acc_cleared", int'($signed(acc_dbg)), 0);
                end
                check("win_done_width", prev_wd, 0);
            end else if (exp_q.size() > 0 && cyc > exp_q[0].at_cyc) begin
                check("missed_win_done", cyc, exp_q[0].at_cyc);
                void'(exp_q.pop_front());
            end
            if (step) check("step_without_win_done", win_done, 1);
        end
        prev_acc = int'($signed(acc_dbg));
        prev_wd  = win_done;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int bias;
        // Reset held for three clocks, then released between edges
        rstb = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");
        #3 rstb = 1'b1;

        // Strong up window, then votes injected during decide/hold are dropped
        window(8, 0);
        window(3, 0);
        idle(6);
        // Strong down window, then a balanced window leaves direction alone
        idle(4);
        window(0, 8);
        idle(4);
        for (int i = 0; i < 4; i++) begin
            vote(1'b1, 1'b1);
            vote(1'b1, 1'b0);
        end
        idle(4);
        // Threshold boundary: +4 steps, +2 does not
        window(6, 2);
        idle(4);
        window(5, 3);
        idle(4);
        // Sparse valid: window closes only on the 8th valid vote
        for (int i = 0; i < 8; i++) begin
            vote(1'b1, 1'b0);
            vote(1'b0, 1'b1);
            vote(1'b0, 1'b0);
        end
        idle(4);
        // Partial sparse window, then asynchronous reset discards it
        for (int i = 0; i < 5; i++) begin
            vote(1'b1, 1'b1);
            vote(1'b0, 1'b0);
            vote(1'b0, 1'b1);
        end
        check("partial_acc", int'($signed(acc_dbg)), 5);
        @(negedge clk);
        #2 rstb = 1'b0;
        pd_valid = 1'b0;
        model_reset();
        #1 check_reset_state("async");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #3 rstb = 1'b1;
        window(8, 0);
        idle(4);
        // Lock sequence: four balanced windows, then one strong up window
        for (int w = 0; w < 4; w++) begin
            window(4, 4);
            idle(4);
        end
        window(8, 0);
        idle(4);
        // Randomised traffic with a slowly changing bias
        bias = 50;
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) bias = $urandom_range(0, 100);
            vote($urandom_range(0, 99) < 70, $urandom_range(0, 99) < bias);
        end
        idle(8);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
